hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_reg_counter.sv | 36 +++
 rtl/hazard_scoreboard.sv | 114 +++++++++++
 tb/tb_hazard_scoreboard.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the hazard scoreboard slice:
//   pipe_sig_e      - pipeline-register control encoding (pass / stall / flush)
//   DEFAULT_*_LAT   - default load-use and mult/div latencies
//   *_CNT_W         - countdown widths able to hold the largest legal latency
package hazard_pkg;

    typedef enum logic [1:0] {
        SIG_PASS  = 2'd0,
        SIG_STALL = 2'd1,
        SIG_FLUSH = 2'd2
    } pipe_sig_e;

    localparam int DEFAULT_LOAD_LAT = 1;
    localparam int DEFAULT_MD_LAT   = 4;

    // LOAD_LAT is at most 7, MD_LAT at most 31.
    localparam int LOAD_CNT_W = 3;
    localparam int MD_CNT_W   = 5;

endpackage

// File: rtl/hazard_reg_counter.sv
// hazard_reg_counter
// One saturating countdown: loads a latency on 'load', otherwise counts down
// to zero and stays there. 'busy' is high whenever the count is nonzero.
// Ports:
//   Clk       in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset, clears the count
//   load      in   load load_val this cycle (wins over the decrement)
//   load_val  in   WIDTH  value to load
//   busy      out  count != 0
module hazard_reg_counter
    import hazard_pkg::*;
#(
    parameter int WIDTH = LOAD_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             busy
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks GPRs whose loaded value is not yet forwardable and the occupancy of
// the mult/div unit, and produces PC / IF-ID / ID-EX control for the
// instruction sitting in ID.
// Ports:
//   Clk, Reset_n                    clock, asynchronous active-low reset
//   ID_Valid                        ID holds a real instruction
//   ID_Rs, ID_Rt, ID_UsesRs/Rt      source indices and whether they are read
//   ID_Rd, ID_RegWrite              destination index and write enable
//   ID_IsLoad, ID_IsMulDiv,
//   ID_UsesHiLo                     instruction class
//   PCSrc                           branch/jump taken this cycle
//   PC_Write                        1 = PC holds
//   IF_ID_Signal, ID_EX_Signal      0 pass, 1 stall, 2 flush
//   MD_Busy                         mult/div unit occupied
//   Pending                         per-GPR load result outstanding
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = DEFAULT_LOAD_LAT,
    parameter int MD_LAT   = DEFAULT_MD_LAT
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                ID_Valid,
    input  logic [REG_AW-1:0]   ID_Rs,
    input  logic [REG_AW-1:0]   ID_Rt,
    input  logic                ID_UsesRs,
    input  logic                ID_UsesRt,
    input  logic [REG_AW-1:0]   ID_Rd,
    input  logic                ID_RegWrite,
    input  logic                ID_IsLoad,
    input  logic                ID_IsMulDiv,
    input  logic                ID_UsesHiLo,
    input  logic                PCSrc,
    output logic                PC_Write,
    output logic [1:0]          IF_ID_Signal,
    output logic [1:0]          ID_EX_Signal,
    output logic                MD_Busy,
    output logic [NUM_REGS-1:0] Pending
);

    localparam int IDX_SPAN = 1 << REG_AW;

    logic [NUM_REGS-1:1] reg_busy;
    logic [IDX_SPAN-1:0] pending_idx;
    logic                rs_hazard;
    logic                rt_hazard;
    logic                md_hazard;
    logic                stall;
    logic                issue;
    logic                load_issue;
    logic                md_issue;

    // Register 0 has no counter, so it can never be reported pending.
    assign Pending = {reg_busy, 1'b0};

    // Widen to the full index space so any ID_Rs/ID_Rt value indexes safely;
    // indices beyond NUM_REGS read as not pending.
    assign pending_idx = IDX_SPAN'(Pending);

    assign rs_hazard = ID_UsesRs && pending_idx[ID_Rs];
    assign rt_hazard = ID_UsesRt && pending_idx[ID_Rt];
    assign md_hazard = (ID_UsesHiLo || ID_IsMulDiv) && MD_Busy;
    assign stall     = ID_Valid && (rs_hazard || rt_hazard || md_hazard);

    // A flushed or stalled instruction must not touch any counter.
    assign issue      = ID_Valid && !stall && !PCSrc;
    assign load_issue = issue && ID_IsLoad && ID_RegWrite && (ID_Rd != '0);
    assign md_issue   = issue && ID_IsMulDiv;

    // Only loads arm a register counter; ALU results are fully forwarded.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        hazard_reg_counter #(
            .WIDTH(LOAD_CNT_W)
        ) u_ctr (
            .Clk     (Clk),
            .Reset_n (Reset_n),
            .load    (load_issue && (ID_Rd == REG_AW'(i))),
            .load_val(LOAD_CNT_W'(LOAD_LAT)),
            .busy    (reg_busy[i])
        );
    end

    hazard_reg_counter #(
        .WIDTH(MD_CNT_W)
    ) u_md_ctr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (md_issue),
        .load_val(MD_CNT_W'(MD_LAT)),
        .busy    (MD_Busy)
    );

    // A taken branch outranks a stall: the ID instruction is discarded
    // anyway, so waiting on its operands would only cost cycles.
    always_comb begin
        PC_Write     = 1'b0;
        IF_ID_Signal = SIG_PASS;
        ID_EX_Signal = SIG_PASS;
        if (PCSrc) begin
            PC_Write     = 1'b0;
            IF_ID_Signal = SIG_FLUSH;
            ID_EX_Signal = SIG_FLUSH;
        end else if (stall) begin
            PC_Write     = 1'b1;
            IF_ID_Signal = SIG_STALL;
            ID_EX_Signal = SIG_FLUSH;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed scenarios plus randomized traffic against a reference model that
// records, per register, the cycle at which a loaded value becomes usable.
module tb_hazard_scoreboard;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int LL = 1;
    localparam int ML = 4;

    logic          Clk;
    logic          Reset_n;
    logic          ID_Valid;
    logic [AW-1:0] ID_Rs;
    logic [AW-1:0] ID_Rt;
    logic          ID_UsesRs;
    logic          ID_UsesRt;
    logic [AW-1:0] ID_Rd;
    logic          ID_RegWrite;
    logic          ID_IsLoad;
    logic          ID_IsMulDiv;
    logic          ID_UsesHiLo;
    logic          PCSrc;
    logic          PC_Write;
    logic [1:0]    IF_ID_Signal;
    logic [1:0]    ID_EX_Signal;
    logic          MD_Busy;
    logic [NR-1:0] Pending;

    int cyc;
    int ready_at [NR];
    int md_ready_at;
    int checks;
    int passed;

    hazard_scoreboard #(
        .NUM_REGS(NR),
        .REG_AW  (AW),
        .LOAD_LAT(LL),
        .MD_LAT  (ML)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .ID_Valid    (ID_Valid),
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .ID_UsesRs   (ID_UsesRs),
        .ID_UsesRt   (ID_UsesRt),
        .ID_Rd       (ID_Rd),
        .ID_RegWrite (ID_RegWrite),
        .ID_IsLoad   (ID_IsLoad),
        .ID_IsMulDiv (ID_IsMulDiv),
        .ID_UsesHiLo (ID_UsesHiLo),
        .PCSrc       (PCSrc),
        .PC_Write    (PC_Write),
        .IF_ID_Signal(IF_ID_Signal),
        .ID_EX_Signal(ID_EX_Signal),
        .MD_Busy     (MD_Busy),
        .Pending     (Pending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: a register is unusable until its ready cycle.
    function automatic bit m_pend(input int r);
        return (r != 0) && (cyc < ready_at[r]);
    endfunction

    function automatic bit m_md();
        return cyc < md_ready_at;
    endfunction

    function automatic bit m_stall();
        return ID_Valid && ((ID_UsesRs && m_pend(int'(ID_Rs))) ||
                            (ID_UsesRt && m_pend(int'(ID_Rt))) ||
                            ((ID_UsesHiLo || ID_IsMulDiv) && m_md()));
    endfunction

    function automatic logic [37:0] m_out();
        logic [NR-1:0] p;
        logic          md;
        for (int i = 0; i < NR; i++) p[i] = m_pend(i);
        md = m_md();
        if (PCSrc) return {1'b0, 2'd2, 2'd2, md, p};
        if (m_stall()) return {1'b1, 2'd1, 2'd2, md, p};
        return {1'b0, 2'd0, 2'd0, md, p};
    endfunction

    function automatic logic [37:0] obs();
        return {PC_Write, IF_ID_Signal, ID_EX_Signal, MD_Busy, Pending};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) ready_at[i] = 0;
        md_ready_at = 0;
    endtask

    task automatic set_instr(input logic v, input int rs, input logic urs,
                             input int rt, input logic urt, input int rd,
                             input logic rw, input logic ld, input logic md,
                             input logic hilo, input logic pc);
        ID_Valid    = v;
        ID_Rs       = AW'(rs);
        ID_UsesRs   = urs;
        ID_Rt       = AW'(rt);
        ID_UsesRt   = urt;
        ID_Rd       = AW'(rd);
        ID_RegWrite = rw;
        ID_IsLoad   = ld;
        ID_IsMulDiv = md;
        ID_UsesHiLo = hilo;
        PCSrc       = pc;
    endtask

    task automatic set_idle();
        set_instr(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock and let the model absorb whatever issued.
    task automatic tick();
        bit iss;
        iss = Reset_n && ID_Valid && !m_stall() && !PCSrc;
        @(posedge Clk);
        cyc++;
        if (iss) begin
            if (ID_IsLoad && ID_RegWrite && ID_Rd != '0) ready_at[ID_Rd] = cyc + LL;
            if (ID_IsMulDiv) md_ready_at = cyc + ML;
        end
        #1;
    endtask

    task automatic settle();
        set_idle();
        repeat (ML + 2) tick();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        set_idle();
        model_reset();
        #1;
        checks++;
        if (obs() !== 38'd0) $display("[TB] FAIL reset_idle: got %h required %h", obs(), 38'd0);
        else passed++;
        tick();
        tick();
        Reset_n = 1'b1;
        #1;
        checks++;
        if (obs() !== m_out()) $display("[TB] FAIL reset_release: got %h required %h", obs(), m_out());
        else passed++;
    endtask

    task automatic test_load_use();
        int n_stall;
        int n_pend8;
        int issued;
        logic went;
        settle();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs() !== m_out()) $display("[TB] FAIL load_issue: got %h required %h", obs(), m_out());
        else passed++;
        tick();
        set_instr(1'b1, 8, 1'b1, 1, 1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_stall = 0;
        n_pend8 = 0;
        issued  = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (obs() !== m_out()) $display("[TB] FAIL load_use_cycle: got %h required %h", obs(), m_out());
            else passed++;
            if (PC_Write) n_stall++;
            if (Pending[8]) n_pend8++;
            went = !PC_Write;
            tick();
            if (went) begin
                issued = 1;
                break;
            end
        end
        checks++;
        if (issued != 1 || n_stall != 1 || n_pend8 != 1)
            $display("[TB] FAIL load_use_counts: got issued=%0d stalls=%0d pend8=%0d required 1/1/1", issued, n_stall, n_pend8);
        else passed++;
        set_idle();
    endtask

    task automatic test_alu_forward();
        settle();
        set_instr(1'b1, 1, 1'b1, 2, 1'b1, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs() !== m_out()) $display("[TB] FAIL alu_issue: got %h required %h", obs(), m_out());
        else passed++;
        tick();
        set_instr(1'b1, 8, 1'b1, 3, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs() !== m_out()) $display("[TB] FAIL alu_consumer: got %h required %h", obs(), m_out());
        else passed++;
        checks++;
        if ({PC_Write, Pending} !== 33'd0) $display("[TB] FAIL alu_no_stall: got %h required 0", {PC_Write, Pending});
        else passed++;
        tick();
        set_idle();
    endtask

    task automatic test_muldiv();
        int n_stall;
        int n_busy;
        logic went;
        settle();
        set_instr(1'b1, 4, 1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs() !== m_out()) $display("[TB] FAIL mult_issue: got %h required %h", obs(), m_out());
        else passed++;
        tick();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_stall = 0;
        n_busy  = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            checks++;
            if (obs() !== m_out()) $display("[TB] FAIL mflo_cycle: got %h required %h", obs(), m_out());
            else passed++;
            if (PC_Write) n_stall++;
            if (MD_Busy) n_busy++;
            went = !PC_Write;
            tick();
            if (went) break;
        end
        checks++;
        if (n_stall != ML || n_busy != ML)
            $display("[TB] FAIL mflo_counts: got stalls=%0d busy=%0d required %0d/%0d", n_stall, n_busy, ML, ML);
        else passed++;
        set_idle();
    endtask

    task automatic test_branch_priority();
        settle();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        tick();
        set_instr(1'b1, 10, 1'b1, 0, 1'b0, 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (obs() !== m_out()) $display("[TB] FAIL branch_model: got %h required %h", obs(), m_out());
        else passed++;
        checks++;
        if ({PC_Write, IF_ID_Signal, ID_EX_Signal} !== 5'b0_10_10)
            $display("[TB] FAIL branch_ctrl: got %b required 01010", {PC_Write, IF_ID_Signal, ID_EX_Signal});
        else passed++;
        tick();
        set_idle();
        #1;
        checks++;
        if (Pending[11] !== 1'b0) $display("[TB] FAIL branch_rd_pending: got %b required 0", Pending[11]);
        else passed++;
        checks++;
        if (obs() !== m_out()) $display("[TB] FAIL branch_after: got %h required %h", obs(), m_out());
        else passed++;
    endtask

    task automatic test_zero_reg();
        settle();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        tick();
        set_instr(1'b1, 0, 1'b1, 0, 1'b1, 12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs() !== m_out()) $display("[TB] FAIL zero_model: got %h required %h", obs(), m_out());
        else passed++;
        checks++;
        if ({PC_Write, Pending} !== 33'd0) $display("[TB] FAIL zero_no_stall: got %h required 0", {PC_Write, Pending});
        else passed++;
        tick();
        set_idle();
    endtask

    task automatic test_async_reset();
        settle();
        set_instr(1'b1, 4, 1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        tick();
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        tick();
        set_idle();
        #1;
        checks++;
        if ({MD_Busy, Pending[8]} !== 2'b11) $display("[TB] FAIL areset_setup: got %b required 11", {MD_Busy, Pending[8]});
        else passed++;
        #1;
        Reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({MD_Busy, Pending} !== 33'd0) $display("[TB] FAIL areset_clear: got %h required 0", {MD_Busy, Pending});
        else passed++;
        tick();
        Reset_n = 1'b1;
        set_instr(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (obs() !== m_out()) $display("[TB] FAIL areset_mflo: got %h required %h", obs(), m_out());
        else passed++;
        checks++;
        if (PC_Write !== 1'b0) $display("[TB] FAIL areset_mflo_stall: got %b required 0", PC_Write);
        else passed++;
        tick();
        set_idle();
    endtask

    task automatic test_random();
        settle();
        for (int n = 0; n < 400; n++) begin
            set_instr($urandom_range(0, 7) != 0,
                      int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            #1;
            checks++;
            if (obs() !== m_out()) $display("[TB] FAIL random_cyc%0d: got %h required %h", n, obs(), m_out());
            else passed++;
            tick();
        end
        set_idle();
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        passed = 0;
        model_reset();
        test_reset();
        test_load_use();
        test_alu_forward();
        test_muldiv();
        test_branch_priority();
        test_zero_reg();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
